// File: rtl/vga_pkg.sv
// Geometry, pixel type and capture state encoding shared by the camera
// capture path, the frame buffer and the VGA read side.
package vga_pkg;

  localparam int H_PIX   = 320;
  localparam int V_LINES = 240;
  localparam int ADDR_W  = 17;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  typedef enum logic [1:0] {
    S_WAIT_VS,
    S_VSYNC,
    S_ACTIVE
  } cap_state_t;

endpackage

// File: rtl/ov7670_capture_if.sv
// Frame buffer write port: one strobe, a linear address and an RGB444 word.
interface ov7670_capture_if
  import vga_pkg::*;
#(
  parameter int ADDR_W = vga_pkg::ADDR_W
);

  logic              we;
  logic [ADDR_W-1:0] wAddr;
  rgb444_t           wData;

  modport master (output we, output wAddr, output wData);
  modport slave  (input  we, input  wAddr, input  wData);

endinterface

// File: rtl/ov7670_capture_cam_pixel_pack.sv
// Pairs camera bytes into pixels and converts them to RGB444; a pixel is
// reported one cycle after its second byte is seen.
module cam_pixel_pack
  import vga_pkg::*;
#(
  parameter int FMT_565 = 1
) (
  input  logic       pclk,
  input  logic       reset_n,
  input  logic       en,
  input  logic       hr,
  input  logic [7:0] din,
  output logic       pix_valid,
  output rgb444_t    pix
);

  logic       phase;
  logic [7:0] hi;

  function automatic rgb444_t to_rgb444(input logic [7:0] b_hi, input logic [7:0] b_lo);
    rgb444_t p;
    if (FMT_565 != 0) begin
      p.r = b_hi[7:4];
      p.g = {b_hi[2:0], b_lo[7]};
      p.b = b_lo[4:1];
    end else begin
      p.r = b_hi[3:0];
      p.g = b_lo[7:4];
      p.b = b_lo[3:0];
    end
    return p;
  endfunction

  // A low href or an inactive capture realigns pairing, dropping any dangling byte.
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      phase     <= 1'b0;
      pix_valid <= 1'b0;
    end else begin
      pix_valid <= en && hr && phase;
      if (!en || !hr) phase <= 1'b0;
      else            phase <= ~phase;
    end
  end

  always_ff @(posedge pclk) begin
    if (en && hr && !phase) hi  <= din;
    if (en && hr && phase)  pix <= to_rgb444(hi, din);
  end

endmodule

// File: rtl/ov7670_capture.sv
// OV7670 capture: frames camera bytes by vsync/href, writes RGB444 pixels to a
// linear frame buffer and reports frame boundaries and geometry errors.
module ov7670_capture
  import vga_pkg::*;
#(
  parameter int H_PIX   = vga_pkg::H_PIX,
  parameter int V_LINES = vga_pkg::V_LINES,
  parameter int ADDR_W  = vga_pkg::ADDR_W,
  parameter int FMT_565 = 1
) (
  input  logic                 pclk,
  input  logic                 reset_n,
  input  logic                 vsync,
  input  logic                 href,
  input  logic [7:0]           data,
  input  logic                 capture_en,
  ov7670_capture_if.master     wr,
  output logic                 frame_start,
  output logic                 frame_done,
  output logic                 frame_err,
  output logic [7:0]           frame_cnt
);

  localparam int X_W = $clog2(H_PIX + 1);
  localparam int Y_W = $clog2(V_LINES + 1);
  localparam logic [X_W-1:0]    H_MAX  = X_W'(H_PIX);
  localparam logic [Y_W-1:0]    V_MAX  = Y_W'(V_LINES);
  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(H_PIX);

  logic       vs_q, hr_q, vs_d, hr_d;
  logic [7:0] d_q;
  logic       vs_rise, vs_fall, hr_fall;

  cap_state_t        state;
  logic [X_W-1:0]    x, x_inc, x_nxt;
  logic [Y_W-1:0]    y, y_nxt;
  logic [ADDR_W-1:0] line_base, base_nxt;
  logic              err_flag, err_nxt;
  logic              wr_ok;

  logic    pix_valid;
  rgb444_t pix;

  // Stage 0: input registers plus one extra delay for edge detection
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      vs_q <= 1'b0;
      hr_q <= 1'b0;
      vs_d <= 1'b0;
      hr_d <= 1'b0;
      d_q  <= '0;
    end else begin
      vs_q <= vsync;
      hr_q <= href;
      vs_d <= vs_q;
      hr_d <= hr_q;
      d_q  <= data;
    end
  end

  assign vs_rise = vs_q & ~vs_d;
  assign vs_fall = ~vs_q & vs_d;
  assign hr_fall = ~hr_q & hr_d;

  // Stage 1: byte pairing and format conversion
  cam_pixel_pack #(
    .FMT_565 (FMT_565)
  ) u_pack (
    .pclk      (pclk),
    .reset_n   (reset_n),
    .en        (state == S_ACTIVE),
    .hr        (hr_q),
    .din       (d_q),
    .pix_valid (pix_valid),
    .pix       (pix)
  );

  // A pixel completing on the same cycle as the line end is counted before
  // the line-length test, so the last pixel of every line is not lost.
  always_comb begin
    wr_ok    = pix_valid && (x < H_MAX) && (y < V_MAX);
    x_inc    = x + X_W'(wr_ok);
    err_nxt  = err_flag | (pix_valid & ~wr_ok);
    x_nxt    = x_inc;
    y_nxt    = y;
    base_nxt = line_base;
    if (hr_fall) begin
      if (x_inc != H_MAX) err_nxt = 1'b1;
      if (x_inc != '0) begin
        y_nxt    = y + Y_W'(1);
        base_nxt = line_base + STRIDE;
      end
      x_nxt = '0;
    end
  end

  // Stage 2: frame FSM, addressing and registered write port
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_WAIT_VS;
      wr.we       <= 1'b0;
      wr.wAddr    <= '0;
      wr.wData    <= '0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
      frame_cnt   <= '0;
      x           <= '0;
      y           <= '0;
      line_base   <= '0;
      err_flag    <= 1'b0;
    end else begin
      wr.we       <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      case (state)
        S_WAIT_VS: begin
          if (vs_rise) state <= S_VSYNC;
        end
        S_VSYNC: begin
          if (vs_fall) begin
            if (capture_en) begin
              state       <= S_ACTIVE;
              frame_start <= 1'b1;
              x           <= '0;
              y           <= '0;
              line_base   <= '0;
              err_flag    <= 1'b0;
            end else begin
              state <= S_WAIT_VS;
            end
          end
        end
        S_ACTIVE: begin
          if (wr_ok) begin
            wr.we    <= 1'b1;
            wr.wAddr <= line_base + ADDR_W'(x);
            wr.wData <= pix;
          end
          x         <= x_nxt;
          y         <= y_nxt;
          line_base <= base_nxt;
          err_flag  <= err_nxt;
          if (vs_rise) begin
            frame_done <= 1'b1;
            frame_err  <= err_nxt | (y_nxt != V_MAX);
            frame_cnt  <= frame_cnt + 8'd1;
            state      <= S_VSYNC;
          end
        end
        default: state <= S_WAIT_VS;
      endcase
    end
  end

endmodule
